// File: rtl/pkt_steer_pkg.sv
// pkt_steer_pkg: shared definitions for the ingress packet steering block.
//   - FSM state encodings (IDLE / PKT / DROP)
//   - frame_t: per-beat framing flags carried through the buffer
//   - dest_width(): destination index width, never less than one bit
package pkt_steer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;  // waiting for a start of packet
  localparam logic [1:0] ST_PKT  = 2'd1;  // forwarding a packet to the latched destination
  localparam logic [1:0] ST_DROP = 2'd2;  // discarding a packet with an illegal destination

  typedef struct packed {
    logic sop;
    logic eop;
  } frame_t;

  function automatic int dest_width(input int m);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/pkt_steer_buf.sv
// pkt_steer_buf: two-entry FIFO of {data, frame, dest} beats.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, push_*        write one entry (never issued when count == 2)
//   pop                 remove the head entry (only issued while head_valid)
//   head_valid, head_*  oldest entry; head_data keeps its last value when empty
//   count               number of entries held (0..2)
module pkt_steer_buf
  import pkt_steer_pkg::*;
#(
  parameter int WIDTH = 80,
  parameter int DW    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  frame_t           push_frame,
  input  logic [DW-1:0]    push_dest,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output frame_t           head_frame,
  output logic [DW-1:0]    head_dest,
  output logic [1:0]       count
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    frame_t           frame;
    logic [DW-1:0]    dest;
  } entry_t;

  entry_t slot0;  // head entry, drives the outputs
  entry_t slot1;  // second entry, only meaningful when count == 2
  entry_t push_entry;

  assign push_entry = '{data: push_data, frame: push_frame, dest: push_dest};

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      slot0 <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          // Popping the last entry leaves slot0 alone so out_data holds.
          if (count == 2'd2) slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Pop is only issued with count >= 1, so count stays unchanged.
          if (count == 2'd2) slot0 <= slot1;
          else               slot0 <= push_entry;
        end
        default: ;
      endcase
    end
  end

  // NOTE: slot1 is storage only, never observed while count < 2, so it is
  // deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop))) begin
      slot1 <= push_entry;
    end
  end

  assign head_valid = (count != 2'd0);
  assign head_data  = slot0.data;
  assign head_frame = slot0.frame;
  assign head_dest  = slot0.dest;

endmodule

// File: rtl/pkt_steer.sv
// pkt_steer: ingress packet steering for one input port of the packet switch.
// The destination is sampled on the sop beat and locked for the whole packet.
// Illegal destinations and framing violations are dropped and counted.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_data/sop/eop/valid/dest       ingress beat; in_dest sampled on sop only
//   in_ready                         beat accepted when in_valid & in_ready
//   out_data                         head beat data shared by all destinations
//   out_valid/sop/eop [M]            one-hot per-destination framing
//   out_ready [M]                    per-destination ready from the switch
//   err_bad_dest, err_proto          one-cycle error pulses
//   drop_cnt                         saturating count of dropped packets/orphan beats
module pkt_steer
  import pkt_steer_pkg::*;
#(
  parameter int WIDTH = 80,
  parameter int M     = 2,
  parameter int DW    = dest_width(M),
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_dest,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [M-1:0]     out_sop,
  output logic [M-1:0]     out_eop,
  output logic [M-1:0]     out_valid,
  input  logic [M-1:0]     out_ready,
  output logic             err_bad_dest,
  output logic             err_proto,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [1:0]    state, state_d;
  logic [DW-1:0] dest_q, dest_d;
  logic [1:0]    count;
  logic          accept, dest_ok;
  logic          push, pop;
  frame_t        push_frame;
  logic [DW-1:0] push_dest;
  logic          bad_dest_ev, proto_ev, drop_ev;
  logic          head_valid;
  frame_t        head_frame;
  logic [DW-1:0] head_dest;

  // Ready looks only at the registered fill level (and reset), never at
  // out_ready, so there is no combinational path through the block.
  assign in_ready = !rst && (count < 2'd2);
  assign accept   = in_valid && in_ready;
  assign dest_ok  = (int'(in_dest) < M);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d     = state;
    dest_d      = dest_q;
    push        = 1'b0;
    push_frame  = '{sop: 1'b0, eop: in_eop};
    push_dest   = dest_q;
    bad_dest_ev = 1'b0;
    proto_ev    = 1'b0;
    drop_ev     = 1'b0;
    if (accept) begin
      unique case (state)
        ST_IDLE: begin
          if (!in_sop) begin
            // Orphan beat outside a packet.
            proto_ev = 1'b1;
            drop_ev  = 1'b1;
          end else if (dest_ok) begin
            push           = 1'b1;
            push_frame.sop = 1'b1;
            push_dest      = in_dest;
            dest_d         = in_dest;
            if (!in_eop) state_d = ST_PKT;
          end else begin
            bad_dest_ev = 1'b1;
            drop_ev     = 1'b1;
            if (!in_eop) state_d = ST_DROP;
          end
        end
        ST_PKT: begin
          // A stray sop is forwarded as a continuation beat (sop forced 0).
          push     = 1'b1;
          proto_ev = in_sop;
          if (in_eop) state_d = ST_IDLE;
        end
        ST_DROP: begin
          proto_ev = in_sop;
          if (in_eop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      dest_q       <= '0;
      err_bad_dest <= 1'b0;
      err_proto    <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      state        <= state_d;
      dest_q       <= dest_d;
      err_bad_dest <= bad_dest_ev;
      err_proto    <= proto_ev;
      if (drop_ev && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + 1'b1;
    end
  end

  pkt_steer_buf #(
    .WIDTH (WIDTH),
    .DW    (DW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (in_data),
    .push_frame (push_frame),
    .push_dest  (push_dest),
    .pop        (pop),
    .head_valid (head_valid),
    .head_data  (out_data),
    .head_frame (head_frame),
    .head_dest  (head_dest),
    .count      (count)
  );

  // One-hot decode of the head entry onto its destination lane.
  always_comb begin
    out_valid = '0;
    out_sop   = '0;
    out_eop   = '0;
    for (int i = 0; i < M; i++) begin
      if (head_valid && (int'(head_dest) == i)) begin
        out_valid[i] = 1'b1;
        out_sop[i]   = head_frame.sop;
        out_eop[i]   = head_frame.eop;
      end
    end
  end

  // Only the ready bit of the head's own destination can pop it.
  assign pop = |(out_valid & out_ready);

endmodule

// File: tb/tb_pkt_steer.sv
// tb_pkt_steer: self-checking bench for pkt_steer.
// M = 3 gives a 2-bit in_dest so an illegal destination (3) can be expressed;
// CNT_W = 4 makes drop_cnt saturation reachable in a short run.
module tb_pkt_steer;

  localparam int WIDTH   = 32;
  localparam int M       = 3;
  localparam int DW      = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_sop = 1'b0, in_eop = 1'b0, in_valid = 1'b0;
  logic [DW-1:0]    in_dest = '0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic [M-1:0]     out_sop, out_eop, out_valid;
  logic [M-1:0]     out_ready = '1;
  logic             err_bad_dest, err_proto;
  logic [CNT_W-1:0] drop_cnt;

  always #5 clk = ~clk;

  pkt_steer #(.WIDTH(WIDTH), .M(M), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_sop       (in_sop),
    .in_eop       (in_eop),
    .in_valid     (in_valid),
    .in_dest      (in_dest),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .err_bad_dest (err_bad_dest),
    .err_proto    (err_proto),
    .drop_cnt     (drop_cnt)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    bit               sop;
    bit               eop;
    int               dest;
  } beat_t;

  typedef struct packed {
    logic             in_ready;
    logic [M-1:0]     valid;
    logic [M-1:0]     sop;
    logic [M-1:0]     eop;
    logic [WIDTH-1:0] data;
    logic             bad;
    logic             proto;
    logic [CNT_W-1:0] drop;
  } view_t;

  // Reference model: packet-level rules plus a queue standing for the buffer.
  beat_t            fifo[$];
  beat_t            stim[$];
  int               mode;      // 0 between packets, 1 forwarding, 2 discarding
  int               pkt_dest;
  logic [WIDTH-1:0] last_data;
  bit               m_bad, m_proto;
  int               m_drop;

  view_t obs, want;
  view_t hist[$];
  int    errors = 0;
  int    checks = 0;
  bit    toggle0 = 0;
  bit    rand_mode = 0;

  function automatic view_t expected();
    view_t v = '0;
    v.in_ready = !rst && (fifo.size() < 2);
    if (fifo.size() > 0) begin
      v.valid[fifo[0].dest] = 1'b1;
      v.sop[fifo[0].dest]   = fifo[0].sop;
      v.eop[fifo[0].dest]   = fifo[0].eop;
      v.data                = fifo[0].data;
    end else begin
      v.data = last_data;
    end
    v.bad   = m_bad;
    v.proto = m_proto;
    v.drop  = CNT_W'(m_drop);
    return v;
  endfunction

  task automatic model_edge();
    bit    acc, popping, pushing;
    beat_t b;
    if (rst) begin
      fifo.delete();
      mode = 0; m_bad = 0; m_proto = 0; m_drop = 0; last_data = '0;
      return;
    end
    acc     = in_valid && (fifo.size() < 2);
    popping = (fifo.size() > 0) && out_ready[fifo[0].dest];
    pushing = 0;
    m_bad   = 0;
    m_proto = 0;
    b.data  = in_data; b.sop = 0; b.eop = in_eop; b.dest = pkt_dest;
    if (acc) begin
      if (mode == 0) begin
        if (!in_sop) begin
          m_proto = 1;
          if (m_drop < CNT_MAX) m_drop++;
        end else if (int'(in_dest) < M) begin
          pkt_dest = int'(in_dest);
          b.dest = pkt_dest; b.sop = 1; pushing = 1;
          mode = in_eop ? 0 : 1;
        end else begin
          m_bad = 1;
          if (m_drop < CNT_MAX) m_drop++;
          mode = in_eop ? 0 : 2;
        end
      end else begin
        m_proto = in_sop;
        pushing = (mode == 1);
        if (in_eop) mode = 0;
      end
    end
    if (popping) begin
      last_data = fifo[0].data;
      void'(fifo.pop_front());
    end
    if (pushing) fifo.push_back(b);
  endtask

  // One clock: sample at the falling edge, compare with the model, then
  // advance the model on the rising edge.
  task automatic tick(input string name);
    @(negedge clk);
    obs.in_ready = in_ready;  obs.valid = out_valid;
    obs.sop      = out_sop;   obs.eop   = out_eop;
    obs.data     = out_data;  obs.bad   = err_bad_dest;
    obs.proto    = err_proto; obs.drop  = drop_cnt;
    want = expected();
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s t=%0t got=%p want=%p", name, $time, obs, want);
    end
    hist.push_back(obs);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic add(input logic [WIDTH-1:0] d, input bit s, input bit e, input int dest);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.dest = dest;
    stim.push_back(b);
  endtask

  task automatic step(input string name);
    bit acc;
    if (stim.size() > 0) begin
      in_valid = 1'b1; in_data = stim[0].data; in_sop = stim[0].sop;
      in_eop = stim[0].eop; in_dest = DW'(stim[0].dest);
    end else begin
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    end
    if (rand_mode) begin
      out_ready = M'($urandom_range(0, (1 << M) - 1));
      if ($urandom_range(0, 3) == 0) in_valid = 1'b0;
    end
    if (toggle0) out_ready[0] = ~out_ready[0];
    acc = in_valid && !rst && (fifo.size() < 2);
    tick(name);
    if (acc) void'(stim.pop_front());
  endtask

  task automatic run(input string name, input int bound);
    int n = 0;
    while ((stim.size() > 0 || fifo.size() > 0) && n < bound) begin
      step(name);
      n++;
    end
    checks++;
    if (stim.size() > 0 || fifo.size() > 0) begin
      errors++;
      $display("FAIL %s drain: %0d beats left after %0d cycles, want 0", name,
               stim.size() + fifo.size(), bound);
    end
    step(name);
  endtask

  function automatic int first_valid(input int from);
    for (int i = from; i < hist.size(); i++) if (hist[i].valid != '0) return i;
    return -1;
  endfunction

  function automatic view_t at(input int i);
    if (i < 0 || i >= hist.size()) return '0;
    return hist[i];
  endfunction

  function automatic int count_bad(input int from);
    int c = 0;
    for (int i = from; i < hist.size(); i++) if (hist[i].bad) c++;
    return c;
  endfunction

  function automatic int count_proto(input int from);
    int c = 0;
    for (int i = from; i < hist.size(); i++) if (hist[i].proto) c++;
    return c;
  endfunction

  function automatic int count_valid(input int from);
    int c = 0;
    for (int i = from; i < hist.size(); i++) if (hist[i].valid != '0) c++;
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = '1;
    @(posedge clk); @(posedge clk);
    model_edge();
    #1;
    tick("reset");
    checks++;
    if (obs.in_ready !== 1'b0 || obs.valid !== '0 || obs.data !== '0 || obs.drop !== '0 ||
        obs.bad !== 1'b0 || obs.proto !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got=%p want all zero", obs);
    end
    rst = 1'b0;
    tick("reset_release");
    checks++;
    if (obs.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release in_ready got=%b want=1", obs.in_ready);
    end
  endtask

  task automatic test_single_dest();
    int start = hist.size();
    int k;
    out_ready = '1;
    add(32'hA0, 1, 0, 1); add(32'hA1, 0, 0, 1); add(32'hA2, 0, 1, 1);
    run("single", 20);
    k = first_valid(start);
    checks++;
    if (k != start + 1) begin
      errors++;
      $display("FAIL single_latency first valid at offset %0d want 1", k - start);
    end
    checks++;
    if (at(k).valid !== 3'b010 || at(k+1).valid !== 3'b010 || at(k+2).valid !== 3'b010 ||
        at(k+3).valid !== 3'b000 || at(k).sop !== 3'b010 || at(k+1).sop !== 3'b000 ||
        at(k+2).eop !== 3'b010 || at(k).eop !== 3'b000) begin
      errors++;
      $display("FAIL single_seq got %p / %p / %p", at(k), at(k+1), at(k+2));
    end
  endtask

  task automatic test_back_to_back();
    int           start = hist.size();
    int           k;
    bit           ok = 1;
    logic [M-1:0] seq [5];
    seq[0] = 3'b001; seq[1] = 3'b001; seq[2] = 3'b001; seq[3] = 3'b010; seq[4] = 3'b000;
    add(32'hB0, 1, 0, 0); add(32'hB1, 0, 0, 2); add(32'hB2, 0, 1, 1);
    add(32'hB3, 1, 1, 1);
    run("b2b", 20);
    k = first_valid(start);
    for (int i = 0; i < 5; i++) if (at(k + i).valid !== seq[i]) ok = 0;
    checks++;
    if (!ok || k < 0) begin
      errors++;
      $display("FAIL b2b_order got %b %b %b %b %b want 001 001 001 010 000",
               at(k).valid, at(k+1).valid, at(k+2).valid, at(k+3).valid, at(k+4).valid);
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 3'b101; toggle0 = 1;
    add(32'hC0, 1, 0, 1); add(32'hC1, 0, 0, 1); add(32'hC2, 0, 0, 1); add(32'hC3, 0, 1, 1);
    repeat (6) step("bp_stall");
    n = hist.size();
    checks++;
    if (hist[n-1].in_ready !== 1'b0 || hist[n-3].in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready got=%b,%b want=0,0", hist[n-3].in_ready, hist[n-1].in_ready);
    end
    checks++;
    if (hist[n-1].data !== 32'hC0 || hist[n-2].data !== 32'hC0 || hist[n-3].data !== 32'hC0 ||
        hist[n-1].valid !== 3'b010) begin
      errors++;
      $display("FAIL bp_stable data got=%h,%h,%h valid=%b want=c0 valid=010",
               hist[n-3].data, hist[n-2].data, hist[n-1].data, hist[n-1].valid);
    end
    toggle0 = 0; out_ready = '1;
    run("bp_drain", 20);
    n = hist.size();
    checks++;
    if (hist[n-2].data !== 32'hC3 || hist[n-2].eop !== 3'b010) begin
      errors++;
      $display("FAIL bp_last got data=%h eop=%b want c3 010", hist[n-2].data, hist[n-2].eop);
    end
  endtask

  task automatic test_bad_dest();
    int start = hist.size();
    int base = m_drop;
    add(32'hD0, 1, 0, 3); add(32'hD1, 0, 0, 0); add(32'hD2, 1, 0, 1); add(32'hD3, 0, 1, 2);
    add(32'hE0, 1, 0, 2); add(32'hE1, 0, 1, 0);
    run("bad_dest", 30);
    checks++;
    if (count_bad(start) != 1) begin
      errors++;
      $display("FAIL bad_dest_pulse got %0d cycles want 1", count_bad(start));
    end
    checks++;
    if (count_valid(start) != 2) begin
      errors++;
      $display("FAIL bad_dest_forward got %0d valid cycles want 2", count_valid(start));
    end
    checks++;
    if (obs.drop !== CNT_W'(base + 1)) begin
      errors++;
      $display("FAIL bad_dest_cnt got %0d want %0d", obs.drop, base + 1);
    end
  endtask

  task automatic test_proto();
    int start = hist.size();
    int base = m_drop;
    int hits = 0;
    bit sop_ok = 1;
    add(32'hF0, 0, 0, 0);
    add(32'hF1, 1, 0, 0); add(32'hF2, 1, 0, 2); add(32'hF3, 0, 1, 1);
    run("proto", 30);
    checks++;
    if (count_proto(start) != 2) begin
      errors++;
      $display("FAIL proto_pulses got %0d want 2", count_proto(start));
    end
    checks++;
    if (obs.drop !== CNT_W'(base + 1)) begin
      errors++;
      $display("FAIL proto_cnt got %0d want %0d", obs.drop, base + 1);
    end
    for (int i = start; i < hist.size(); i++) begin
      if (hist[i].valid == 3'b001 && hist[i].data == 32'hF2) begin
        hits++;
        if (hist[i].sop !== 3'b000) sop_ok = 0;
      end
    end
    checks++;
    if (hits != 1 || !sop_ok) begin
      errors++;
      $display("FAIL proto_midsop got %0d beats sop_ok=%0d want 1 beat with sop=0", hits, sop_ok);
    end
  endtask

  task automatic test_reset_mid();
    int start;
    out_ready = '0;
    add(32'h70, 1, 0, 1);
    step("rst_mid");
    step("rst_mid");
    rst = 1'b1;
    step("rst_mid_assert");
    step("rst_mid_hold");
    checks++;
    if (obs.valid !== '0 || obs.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got valid=%b in_ready=%b want 000 0", obs.valid, obs.in_ready);
    end
    rst = 1'b0; out_ready = '1;
    step("rst_mid_release");
    checks++;
    if (obs.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_release in_ready got=%b want=1", obs.in_ready);
    end
    start = hist.size();
    add(32'h71, 0, 1, 0);
    add(32'h72, 1, 1, 2);
    run("rst_mid_after", 20);
    checks++;
    if (count_proto(start) != 1 || count_valid(start) != 1) begin
      errors++;
      $display("FAIL rst_mid_orphan got proto=%0d valid=%0d want 1 1",
               count_proto(start), count_valid(start));
    end
  endtask

  task automatic test_random();
    int start = hist.size();
    int both = 0;
    rand_mode = 1;
    for (int c = 0; c < 1500; c++) begin
      if (stim.size() == 0) begin
        int len = $urandom_range(1, 4);
        int d   = $urandom_range(0, 3);
        int r   = $urandom_range(0, 9);
        if (r == 0) add($urandom, 0, bit'($urandom_range(0, 1)), d);
        for (int i = 0; i < len; i++) begin
          add($urandom, (i == 0) || (r == 1 && i == 1), i == len - 1,
              (i == 0) ? d : $urandom_range(0, 3));
        end
      end
      step("random");
    end
    rand_mode = 0; out_ready = '1;
    run("random_drain", 40);
    for (int i = start; i < hist.size(); i++) if (hist[i].bad && hist[i].proto) both++;
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL random_err_overlap got %0d cycles want 0", both);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CNT_MAX + 5; i++) add(WIDTH'(i), 0, 0, 0);
    run("saturate", 60);
    checks++;
    if (obs.drop !== CNT_W'(CNT_MAX)) begin
      errors++;
      $display("FAIL saturate_cnt got %0d want %0d", obs.drop, CNT_MAX);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_dest();
    test_back_to_back();
    test_backpressure();
    test_bad_dest();
    test_proto();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
